// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between the per-core request lines and the shared-resource arbiter.
// master: requesting side (drives req); slave: arbiter (drives grant and status).
interface rr_hold_arbiter_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MAX_HOLD  = 8
);
  localparam int unsigned IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic [HCW-1:0]       hold_cnt;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output hold_cnt
  );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Work-conserving round-robin arbiter: an owner keeps its grant while it holds req,
// bounded by a MAX_HOLD fairness cap whenever another core is waiting.
module rr_hold_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MAX_HOLD  = 8
) (
  input  logic             clk,
  input  logic             rst,
  rr_hold_arbiter_if.slave bus
);

  localparam int unsigned IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

  // last_owner resets to the top index so the first scan starts at core 0
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_CORES - 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] grant_q, grant_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [HCW-1:0]       hold_q, hold_d;

  logic                 found;
  logic [IDW-1:0]       win;
  int unsigned          scan_idx;
  logic                 others;
  logic                 keep;

  // Rotating priority scan starting just after the previous owner
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_idx = (32'(last_q) + 32'(i) + 32'd1) % NUM_CORES;
      if (!found && bus.req[IDW'(scan_idx)]) begin
        found = 1'b1;
        win   = IDW'(scan_idx);
      end
    end
  end

  // grant_q is one-hot on the owner while OWNED, so masking it leaves the contenders
  assign others = |(bus.req & ~grant_q);
  assign keep   = (state_q == OWNED) && bus.req[owner_q] &&
                  !((hold_q == HOLD_MAX) && others);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;

    if (keep) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HCW'(1);
      end
    end else if (found) begin
      state_d      = OWNED;
      grant_d      = '0;
      grant_d[win] = 1'b1;
      owner_d      = win;
      last_d       = win;
      hold_d       = '0;
    end else begin
      // owner id and rotation pointer are kept so grant_id holds across idle
      state_d = IDLE;
      grant_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == OWNED);
  assign bus.grant_id    = owner_q;
  assign bus.hold_cnt    = hold_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Scoreboard bench for rr_hold_arbiter: three builds (4 cores/cap 4, 4 cores/cap 1,
// 1 core/cap 4) driven by directed vectors; a monitor pops expectations per cycle.
module tb_rr_hold_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_hold_arbiter_if #(.NUM_CORES(4), .MAX_HOLD(4)) a_if ();
  rr_hold_arbiter_if #(.NUM_CORES(4), .MAX_HOLD(1)) b_if ();
  rr_hold_arbiter_if #(.NUM_CORES(1), .MAX_HOLD(4)) c_if ();

  rr_hold_arbiter #(.NUM_CORES(4), .MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  rr_hold_arbiter #(.NUM_CORES(4), .MAX_HOLD(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  rr_hold_arbiter #(.NUM_CORES(1), .MAX_HOLD(4)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    logic [3:0] grant;
    logic       gv;
    logic [1:0] id;
    logic [2:0] hold;
    bit         chk_hold;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  event async_ev;

  task automatic push(input int dut, input string name, input logic [3:0] g, input logic gv,
                      input logic [1:0] id, input logic [2:0] h, input bit ch, input int at);
    exp_t e;
    e.cyc = at; e.dut = dut; e.name = name; e.grant = g; e.gv = gv;
    e.id = id; e.hold = h; e.chk_hold = ch;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [3:0] ra, input logic [3:0] rb, input logic rc);
    @(negedge clk);
    a_if.req = ra;
    b_if.req = rb;
    c_if.req = rc;
  endtask

  task automatic check(input exp_t e);
    logic [3:0] ag;
    logic       agv;
    logic [1:0] aid;
    logic [2:0] ah;
    bit         ok;
    case (e.dut)
      0: begin ag = a_if.grant; agv = a_if.grant_valid; aid = a_if.grant_id; ah = a_if.hold_cnt; end
      1: begin ag = b_if.grant; agv = b_if.grant_valid; aid = b_if.grant_id; ah = 3'(b_if.hold_cnt); end
      default: begin
        ag = 4'(c_if.grant); agv = c_if.grant_valid; aid = 2'(c_if.grant_id); ah = c_if.hold_cnt;
      end
    endcase
    ok = (ag === e.grant) && (agv === e.gv) && (aid === e.id) &&
         (!e.chk_hold || (ah === e.hold));
    n_checks++;
    if (ok) n_pass++;
    else
      $display("FAIL %s cyc=%0d dut=%0d: got grant=%b valid=%b id=%0d hold=%0d, want grant=%b valid=%b id=%0d hold=%0d%s",
               e.name, e.cyc, e.dut, ag, agv, aid, ah, e.grant, e.gv, e.id, e.hold,
               e.chk_hold ? "" : "(any)");
  endtask

  // Monitor: after each edge (or an async event) compare every due expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       cseq  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int         chold [8] = '{0, 0, 0, 1, 2, 3, 3, 0};
    logic [3:0] g;
    int         own;
    exp_t       e;

    a_if.req = '0;
    b_if.req = '0;
    c_if.req = '0;

    // Reset held: outputs stay cleared despite full requests
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      push(0, "rst_a", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1, cyc + 1);
      push(1, "rst_b", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1, cyc + 1);
      push(2, "rst_c", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1, cyc + 1);
    end

    // Hold cap on A (0101), strict rotation on B (1111), single-core follow on C
    for (int k = 0; k < 12; k++) begin
      drive(4'b0101, 4'b1111, (k < 8) ? cseq[k] : 1'b0);
      if (k == 0) rst = 1'b0;
      own = (((k / 4) % 2) == 0) ? 0 : 2;
      g = '0;
      g[own] = 1'b1;
      push(0, "hold_cap", g, 1'b1, 2'(own), 3'(k % 4), 1'b1, cyc + 1);
      g = '0;
      g[k % 4] = 1'b1;
      push(1, "rotate", g, 1'b1, 2'(k % 4), 3'd0, 1'b1, cyc + 1);
      if (k < 8)
        push(2, "single", {3'b000, cseq[k]}, cseq[k], 2'd0, 3'(chold[k]), cseq[k], cyc + 1);
    end

    // Uncontended hold on core 1: saturates at 3 and never releases
    for (int k = 0; k < 20; k++) begin
      drive(4'b0010, 4'b0000, 1'b0);
      push(0, "uncontended", 4'b0010, 1'b1, 2'd1, (k < 3) ? 3'(k) : 3'd3, 1'b1, cyc + 1);
    end

    // Core 3 takes over, then hands off to core 0 (wrap) with no bubble
    drive(4'b1000, 4'b0000, 1'b0);
    push(0, "own3", 4'b1000, 1'b1, 2'd3, 3'd0, 1'b1, cyc + 1);
    drive(4'b1001, 4'b0000, 1'b0);
    push(0, "own3_keep", 4'b1000, 1'b1, 2'd3, 3'd1, 1'b1, cyc + 1);
    drive(4'b0001, 4'b0000, 1'b0);
    push(0, "handoff_wrap", 4'b0001, 1'b1, 2'd0, 3'd0, 1'b1, cyc + 1);
    drive(4'b0000, 4'b0000, 1'b0);
    push(0, "release", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, cyc + 1);
    drive(4'b0000, 4'b0000, 1'b0);
    push(0, "idle_hold_id", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b0, cyc + 1);

    // Core 2 owns, then reset is asserted between edges
    drive(4'b0100, 4'b0000, 1'b0);
    push(0, "own2", 4'b0100, 1'b1, 2'd2, 3'd0, 1'b1, cyc + 1);
    drive(4'b0100, 4'b0000, 1'b0);
    push(0, "own2_keep", 4'b0100, 1'b1, 2'd2, 3'd1, 1'b1, cyc + 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    push(0, "async_clr", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1, cyc);
    ->async_ev;
    push(0, "rst_mid", 4'b0000, 1'b0, 2'd0, 3'd0, 1'b1, cyc + 1);
    drive(4'b1111, 4'b0000, 1'b0);
    rst = 1'b0;
    push(0, "post_rst", 4'b0001, 1'b1, 2'd0, 3'd0, 1'b1, cyc + 1);
    drive(4'b1111, 4'b0000, 1'b0);
    push(0, "post_rst_keep", 4'b0001, 1'b1, 2'd0, 3'd1, 1'b1, cyc + 1);

    drive(4'b0000, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      $display("FAIL %s cyc=%0d dut=%0d: got no sample, want grant=%b", e.name, e.cyc, e.dut, e.grant);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
